// File: rtl/vtx_vote_pipe.sv
// rtl/vtx_vote_pipe.sv - unanimity classifier with streak-qualified commit and registered output beat
module vtx_vote_pipe #(
   parameter int VOTERS = 5,
   parameter int DATA_W = 4,
   parameter int HOLD   = 3,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [VOTERS-1:0] votes,
   input  logic [DATA_W-1:0] data_hi,
   input  logic [DATA_W-1:0] data_lo,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_dir,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        lock_state
);

   typedef enum logic [1:0] {
      CLS_MIX = 2'b00,
      CLS_LO  = 2'b01,
      CLS_HI  = 2'b10
   } cls_t;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      LOCK_LO = 2'b01,
      LOCK_HI = 2'b10
   } lock_t;

   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   logic [CNT_W-1:0]  r_streak;
   cls_t              r_streak_cls;
   lock_t             r_lock;
   logic              r_out_valid;
   logic              r_out_dir;
   logic [DATA_W-1:0] r_out_data;

   cls_t              w_cls;
   lock_t             w_cls_lock;
   logic [CNT_W-1:0]  w_next_streak;
   logic              w_accept;
   logic              w_commit;

   // Classify the current voter vector and map it to the lock code it would commit to
   always_comb begin
      w_cls = CLS_MIX;
      if (&votes) begin
         w_cls = CLS_HI;
      end else if (~|votes) begin
         w_cls = CLS_LO;
      end
      w_cls_lock = (w_cls == CLS_HI) ? LOCK_HI : LOCK_LO;
   end

   // Streak value that would result from accepting the current sample
   always_comb begin
      w_next_streak = '0;
      if (w_cls == CLS_MIX) begin
         w_next_streak = '0;
      end else if ((w_cls == r_streak_cls) && (r_streak != '0)) begin
         w_next_streak = (r_streak >= HOLD_C) ? HOLD_C : (r_streak + ONE_C);
      end else begin
         w_next_streak = ONE_C;
      end
   end

   assign in_ready   = !r_out_valid || out_ready;
   assign w_accept   = in_valid && in_ready;
   assign w_commit   = w_accept && (w_cls != CLS_MIX) && (w_next_streak == HOLD_C)
                       && (r_lock != w_cls_lock);

   assign out_valid  = r_out_valid;
   assign out_dir    = r_out_dir;
   assign out_data   = r_out_data;
   assign lock_state = r_lock;

   // Streak counter and its class advance only on accepted samples; MIX keeps the class
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_streak     <= '0;
         r_streak_cls <= CLS_LO;
      end else if (w_accept) begin
         r_streak <= w_next_streak;
         if (w_cls != CLS_MIX) begin
            r_streak_cls <= w_cls;
         end
      end
   end

   // Lock FSM and output register: a commit loads a fresh beat, otherwise a taken beat clears
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock      <= IDLE;
         r_out_valid <= 1'b0;
         r_out_dir   <= 1'b0;
         r_out_data  <= '0;
      end else if (w_commit) begin
         r_lock      <= w_cls_lock;
         r_out_valid <= 1'b1;
         r_out_dir   <= (w_cls == CLS_HI);
         r_out_data  <= (w_cls == CLS_HI) ? data_hi : data_lo;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vtx_vote_pipe.sv
// tb/tb_vtx_vote_pipe.sv - randomized and directed self-checking bench for vtx_vote_pipe
module tb_vtx_vote_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [4:0] votes = 5'b0;
   logic [3:0] data_hi = 4'h0;
   logic [3:0] data_lo = 4'h0;
   logic       out_ready_a = 1'b1;
   logic       out_ready_b = 1'b1;

   logic       in_ready_a, out_valid_a, out_dir_a;
   logic [3:0] out_data_a;
   logic [1:0] lock_a;
   logic       in_ready_b, out_valid_b, out_dir_b;
   logic [3:0] out_data_b;
   logic [1:0] lock_b;

   int checks = 0;
   int errors = 0;

   // reference state per instance: 0 = HOLD 3, 1 = HOLD 1
   bit         m_valid [2];
   bit         m_dir   [2];
   logic [3:0] m_data  [2];
   logic [1:0] m_lock  [2];
   int         m_run   [2];
   int         m_last  [2];

   vtx_vote_pipe #(.VOTERS(5), .DATA_W(4), .HOLD(3), .CNT_W(4)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .votes(votes),
      .data_hi(data_hi), .data_lo(data_lo), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_dir(out_dir_a), .out_data(out_data_a), .lock_state(lock_a)
   );

   vtx_vote_pipe #(.VOTERS(5), .DATA_W(4), .HOLD(1), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .votes(votes),
      .data_hi(data_hi), .data_lo(data_lo), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_dir(out_dir_b), .out_data(out_data_b), .lock_state(lock_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // 2 = all ones, 1 = all zeros, 0 = mixed
   function automatic int cls_of(input logic [4:0] v);
      if (v == 5'b11111) return 2;
      if (v == 5'b00000) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 1'b0;
         m_dir[k]   = 1'b0;
         m_data[k]  = 4'h0;
         m_lock[k]  = 2'b00;
         m_run[k]   = 0;
         m_last[k]  = 0;
      end
   endtask

   // run length = number of most recent accepted samples sharing one unanimous class
   task automatic model_step(input int k, input bit rdy);
      int  h;
      int  c;
      bit  acc;
      h   = (k == 0) ? 3 : 1;
      acc = in_valid && (!m_valid[k] || rdy);
      if (m_valid[k] && rdy) m_valid[k] = 1'b0;
      if (acc) begin
         c = cls_of(votes);
         if (c == 0) m_run[k] = 0;
         else if (c == m_last[k] && m_run[k] > 0) m_run[k] = m_run[k] + 1;
         else m_run[k] = 1;
         m_last[k] = c;
         if (c != 0 && m_run[k] >= h && m_lock[k] != 2'(c)) begin
            m_valid[k] = 1'b1;
            m_dir[k]   = (c == 2);
            m_data[k]  = (c == 2) ? data_hi : data_lo;
            m_lock[k]  = 2'(c);
         end
      end
   endtask

   task automatic check_regs();
      chk("a_out_valid", 32'(out_valid_a), 32'(m_valid[0]));
      chk("a_lock",      32'(lock_a),      32'(m_lock[0]));
      if (m_valid[0]) begin
         chk("a_out_dir",  32'(out_dir_a),  32'(m_dir[0]));
         chk("a_out_data", 32'(out_data_a), 32'(m_data[0]));
      end
      chk("b_out_valid", 32'(out_valid_b), 32'(m_valid[1]));
      chk("b_lock",      32'(lock_b),      32'(m_lock[1]));
      if (m_valid[1]) begin
         chk("b_out_dir",  32'(out_dir_b),  32'(m_dir[1]));
         chk("b_out_data", 32'(out_data_b), 32'(m_data[1]));
      end
   endtask

   // called just after a falling edge with inputs driven; checks ready, advances model and DUT
   task automatic tick();
      #1;
      chk("a_in_ready", 32'(in_ready_a), 32'(!m_valid[0] || out_ready_a));
      chk("b_in_ready", 32'(in_ready_b), 32'(!m_valid[1] || out_ready_b));
      model_step(0, out_ready_a);
      model_step(1, out_ready_b);
      @(posedge clk);
      @(negedge clk);
      check_regs();
   endtask

   task automatic drive(input logic [4:0] v, input logic [3:0] dh, input logic [3:0] dl,
                        input logic iv);
      votes    = v;
      data_hi  = dh;
      data_lo  = dl;
      in_valid = iv;
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_a_out_valid", 32'(out_valid_a), 32'd0);
      chk("rst_a_lock",      32'(lock_a),      32'd0);
      chk("rst_b_out_valid", 32'(out_valid_b), 32'd0);
      chk("rst_b_lock",      32'(lock_b),      32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_regs();
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid_a), 32'd0);
      chk("reset_out_dir",   32'(out_dir_a),   32'd0);
      chk("reset_out_data",  32'(out_data_a),  32'd0);
      chk("reset_lock",      32'(lock_a),      32'd0);
      rst = 1'b0;
      check_regs();

      // three HI samples commit once, further HI samples do not re-emit
      out_ready_a = 1'b1;
      out_ready_b = 1'b1;
      drive(5'b11111, 4'h3, 4'h0, 1'b1); tick();
      drive(5'b11111, 4'h7, 4'h0, 1'b1); tick();
      drive(5'b11111, 4'hA, 4'h0, 1'b1); tick();
      chk("hi_commit_valid", 32'(out_valid_a), 32'd1);
      chk("hi_commit_dir",   32'(out_dir_a),   32'd1);
      chk("hi_commit_data",  32'(out_data_a),  32'hA);
      chk("hi_commit_lock",  32'(lock_a),      32'h2);
      for (int i = 0; i < 5; i++) begin
         drive(5'b11111, 4'(i + 1), 4'h0, 1'b1); tick();
         chk("hi_sat_no_beat", 32'(out_valid_a), 32'd0);
         chk("hi_sat_lock",    32'(lock_a),      32'h2);
      end

      // MIX interrupts the LO streak; commit only on the third post-MIX zero
      async_reset();
      begin
         logic [4:0] seq [6];
         seq = '{5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000};
         for (int i = 0; i < 6; i++) begin
            drive(seq[i], 4'hF, 4'(i + 1), 1'b1); tick();
            if (i == 4) chk("lo_no_early_commit", 32'(out_valid_a), 32'd0);
         end
      end
      chk("lo_commit_valid", 32'(out_valid_a), 32'd1);
      chk("lo_commit_dir",   32'(out_dir_a),   32'd0);
      chk("lo_commit_data",  32'(out_data_a),  32'h6);
      chk("lo_commit_lock",  32'(lock_a),      32'h1);

      // backpressure: the beat holds and input is refused until downstream takes it
      async_reset();
      for (int i = 0; i < 3; i++) begin
         drive(5'b11111, 4'h9, 4'h0, 1'b1); tick();
      end
      drive(5'b00000, 4'h0, 4'h0, 1'b0); tick();
      out_ready_a = 1'b0;
      out_ready_b = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(5'b00000, 4'h0, 4'h5, 1'b1); tick();
      end
      chk("stall_beat_valid", 32'(out_valid_a), 32'd1);
      chk("stall_beat_data",  32'(out_data_a),  32'h5);
      for (int i = 0; i < 4; i++) begin
         drive(5'($urandom), 4'($urandom), 4'($urandom), 1'b1);
         #1 chk("stall_in_ready_low", 32'(in_ready_a), 32'd0);
         tick();
         chk("stall_hold_valid", 32'(out_valid_a), 32'd1);
         chk("stall_hold_dir",   32'(out_dir_a),   32'd0);
         chk("stall_hold_data",  32'(out_data_a),  32'h5);
      end
      out_ready_a = 1'b1;
      #1 chk("stall_release_ready", 32'(in_ready_a), 32'd1);
      drive(5'b00000, 4'h0, 4'h0, 1'b0); tick();
      chk("stall_beat_done", 32'(out_valid_a), 32'd0);

      // HOLD=1 instance: every alternating unanimous sample commits
      async_reset();
      out_ready_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive((i % 2 == 0) ? 5'b11111 : 5'b00000, 4'hC, 4'h3, 1'b1); tick();
         chk("alt_valid", 32'(out_valid_b), 32'd1);
         chk("alt_dir",   32'(out_dir_b),   32'((i % 2) == 0));
         chk("alt_lock",  32'(lock_b),      (i % 2 == 0) ? 32'h2 : 32'h1);
      end

      // async reset mid-streak with a pending beat; the streak restarts from zero
      async_reset();
      out_ready_a = 1'b1;
      out_ready_b = 1'b0;
      drive(5'b11111, 4'hE, 4'h0, 1'b1); tick();
      drive(5'b11111, 4'hE, 4'h0, 1'b1); tick();
      chk("pre_rst_b_pending", 32'(out_valid_b), 32'd1);
      async_reset();
      out_ready_b = 1'b1;
      drive(5'b11111, 4'hB, 4'h0, 1'b1); tick();
      chk("post_rst_hi1", 32'(out_valid_a), 32'd0);
      drive(5'b11111, 4'hB, 4'h0, 1'b1); tick();
      chk("post_rst_hi2", 32'(out_valid_a), 32'd0);
      drive(5'b11111, 4'hB, 4'h0, 1'b1); tick();
      chk("post_rst_hi3_valid", 32'(out_valid_a), 32'd1);
      chk("post_rst_hi3_lock",  32'(lock_a),      32'h2);

      // randomized traffic biased toward unanimous votes
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(99) == 0) begin
            async_reset();
         end else begin
            int r;
            logic [4:0] v;
            r = $urandom_range(9);
            v = (r < 4) ? 5'b11111 : (r < 8) ? 5'b00000 : 5'($urandom);
            out_ready_a = ($urandom_range(3) != 0);
            out_ready_b = ($urandom_range(3) != 0);
            drive(v, 4'($urandom), 4'($urandom), $urandom_range(4) != 0);
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
